// File: rtl/pc_sequencer_if.sv
// Signal bundle between the fetch sequencer and its environment
// (hazard logic, instruction memory and the PC register).
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pc_cur;
    logic             imem_ready;
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic             halt;
    logic             imem_req;
    logic [WIDTH-1:0] pc_next;
    logic             pc_we;
    logic             flush;
    logic             halted;
    logic [1:0]       dbg_state;

    // imem_ready is a single-cycle acknowledge of the fetch at pc_cur while
    // imem_req is high; pc_we qualifies pc_next in the same cycle.
    modport slave (
        input  pc_cur, imem_ready, stall, branch_taken, branch_target, halt,
        output imem_req, pc_next, pc_we, flush, halted, dbg_state
    );

    modport master (
        output pc_cur, imem_ready, stall, branch_taken, branch_target, halt,
        input  imem_req, pc_next, pc_we, flush, halted, dbg_state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: chooses reset vector, PC+INC or a branch target
// each cycle, deferring redirects that land while a fetch is outstanding.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter int               INC       = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave io_bus
);

    typedef enum logic [1:0] {
        S_RESET      = 2'd0,
        S_RUN        = 2'd1,
        S_WAIT_REDIR = 2'd2,
        S_HALT       = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_halted;
    logic [WIDTH-1:0] r_redir_target;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_redir_next;
    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_pc_we;
    logic             w_imem_req;
    logic             w_flush;

    assign w_pc_inc = io_bus.pc_cur + WIDTH'(INC);

    always_comb begin
        w_next_state = r_state;
        w_redir_next = r_redir_target;
        w_pc_next    = w_pc_inc;
        w_pc_we      = 1'b0;
        w_imem_req   = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_RESET: begin
                w_pc_next    = RESET_VEC;
                w_pc_we      = 1'b1;
                w_flush      = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                w_imem_req = 1'b1;
                if (io_bus.branch_taken && io_bus.imem_ready) begin
                    w_pc_next = io_bus.branch_target;
                    w_pc_we   = 1'b1;
                    w_flush   = 1'b1;
                end else if (io_bus.branch_taken) begin
                    // Fetch still in flight on the wrong path: park the target.
                    w_flush      = 1'b1;
                    w_redir_next = io_bus.branch_target;
                    w_next_state = S_WAIT_REDIR;
                end else if (io_bus.halt) begin
                    w_next_state = S_HALT;
                end else if (io_bus.stall) begin
                    w_pc_we = 1'b0;
                end else if (io_bus.imem_ready) begin
                    w_pc_we = 1'b1;
                end
            end
            S_WAIT_REDIR: begin
                w_imem_req = 1'b1;
                w_flush    = 1'b1;
                if (io_bus.branch_taken) begin
                    w_redir_next = io_bus.branch_target;
                end
                if (io_bus.imem_ready) begin
                    w_pc_next    = io_bus.branch_taken ? io_bus.branch_target
                                                       : r_redir_target;
                    w_pc_we      = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RESET;
            r_halted       <= 1'b0;
            r_redir_target <= '0;
        end else begin
            r_state        <= w_next_state;
            r_redir_target <= w_redir_next;
            r_halted       <= (w_next_state == S_HALT);
        end
    end

    assign io_bus.imem_req  = w_imem_req;
    assign io_bus.pc_next   = w_pc_next;
    assign io_bus.pc_we     = w_pc_we;
    assign io_bus.flush     = w_flush;
    assign io_bus.halted    = r_halted;
    assign io_bus.dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models the PC register and checks pc_cur against an
// expected queue plus the combinational control outputs.
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_pc;

  pc_sequencer_if #(.WIDTH(16)) bus ();

  pc_sequencer #(
    .WIDTH(16),
    .INC(2),
    .RESET_VEC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );

  // clock / PC register
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.pc_we === 1'b1) bus.pc_cur <= bus.pc_next;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic idle_inputs;
    bus.imem_ready    = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 16'h0000;
    bus.halt          = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    exp_q.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus.imem_req, bus.pc_we, bus.flush, bus.halted} !== 4'b0110)
      $display("FAIL reset_ctrl: req/we/flush/halted=%b expected 0110",
               {bus.imem_req, bus.pc_we, bus.flush, bus.halted});
    else n_pass++;
    n_checks++;
    if (bus.pc_next !== 16'h0000)
      $display("FAIL reset_pc_next: got %h expected 0000", bus.pc_next);
    else n_pass++;
    rst = 1'b0;
    settle();
    n_checks++;
    if (bus.imem_req !== 1'b0)
      $display("FAIL reset_cycle_req: got %b expected 0", bus.imem_req);
    else n_pass++;
    exp_q.push_back(16'h0000);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL reset_run_pc: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      settle();
      n_checks++;
      if (bus.imem_req !== 1'b1)
        $display("FAIL run_req: got %b expected 1", bus.imem_req);
      else n_pass++;
      exp_q.push_back(16'(i * 2));
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.pc_cur !== exp_pc)
        $display("FAIL reset_run_pc: got %h expected %h", bus.pc_cur, exp_pc);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    do_reset();
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(16'(i * 2));
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.pc_cur !== exp_pc)
        $display("FAIL stall_pre_pc: got %h expected %h", bus.pc_cur, exp_pc);
      else n_pass++;
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (bus.pc_we !== 1'b0)
        $display("FAIL stall_we: got %b expected 0", bus.pc_we);
      else n_pass++;
      exp_q.push_back(16'h0004);
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.pc_cur !== exp_pc)
        $display("FAIL stall_hold_pc: got %h expected %h", bus.pc_cur, exp_pc);
      else n_pass++;
    end
    bus.stall = 1'b0;
    settle();
    n_checks++;
    if (bus.pc_we !== 1'b1)
      $display("FAIL stall_release_we: got %b expected 1", bus.pc_we);
    else n_pass++;
    exp_q.push_back(16'h0006);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL stall_release_pc: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_miss;
    do_reset();
    repeat (8) tick();
    n_checks++;
    if (bus.pc_cur !== 16'h0010)
      $display("FAIL redir_start_pc: got %h expected 0010", bus.pc_cur);
    else n_pass++;
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if ({bus.flush, bus.pc_we} !== 2'b10)
        $display("FAIL redir_wait_ctrl: flush/we=%b expected 10", {bus.flush, bus.pc_we});
      else n_pass++;
      exp_q.push_back(16'h0010);
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.pc_cur !== exp_pc)
        $display("FAIL redir_wait_pc: got %h expected %h", bus.pc_cur, exp_pc);
      else n_pass++;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 16'h0000;
    end
    bus.imem_ready = 1'b1;
    settle();
    n_checks++;
    if ({bus.flush, bus.pc_we} !== 2'b11 || bus.pc_next !== 16'h0100)
      $display("FAIL redir_ready: flush/we=%b pc_next=%h expected 11 0100",
               {bus.flush, bus.pc_we}, bus.pc_next);
    else n_pass++;
    exp_q.push_back(16'h0100);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL redir_target_pc: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
    settle();
    n_checks++;
    if (bus.flush !== 1'b0)
      $display("FAIL redir_after_flush: got %b expected 0", bus.flush);
    else n_pass++;
    exp_q.push_back(16'h0102);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL redir_after_pc: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0A00;
    tick();
    bus.branch_target = 16'h0B00;
    bus.halt          = 1'b1;
    bus.stall         = 1'b1;
    settle();
    n_checks++;
    if (bus.pc_we !== 1'b0)
      $display("FAIL b2b_wait_we: got %b expected 0", bus.pc_we);
    else n_pass++;
    tick();
    bus.branch_taken  = 1'b0;
    bus.halt          = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_target = 16'h0C00;
    bus.imem_ready    = 1'b1;
    settle();
    n_checks++;
    if (bus.pc_next !== 16'h0B00)
      $display("FAIL b2b_latest_wins: pc_next=%h expected 0B00", bus.pc_next);
    else n_pass++;
    exp_q.push_back(16'h0B00);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc || bus.halted !== 1'b0)
      $display("FAIL b2b_pc_b00: pc_cur=%h halted=%b expected %h 0",
               bus.pc_cur, bus.halted, exp_pc);
    else n_pass++;
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0D00;
    tick();
    bus.imem_ready    = 1'b1;
    bus.branch_target = 16'h0E00;
    settle();
    n_checks++;
    if (bus.pc_we !== 1'b1 || bus.pc_next !== 16'h0E00)
      $display("FAIL b2b_same_cycle: we=%b pc_next=%h expected 1 0E00",
               bus.pc_we, bus.pc_next);
    else n_pass++;
    exp_q.push_back(16'h0E00);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL b2b_pc_e00: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
    for (int i = 1; i <= 2; i++) begin
      bus.branch_target = 16'(i * 16'h1000);
      settle();
      n_checks++;
      if ({bus.pc_we, bus.flush} !== 2'b11)
        $display("FAIL b2b_hit_ctrl: we/flush=%b expected 11", {bus.pc_we, bus.flush});
      else n_pass++;
      exp_q.push_back(16'(i * 16'h1000));
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.pc_cur !== exp_pc)
        $display("FAIL b2b_hit_pc: got %h expected %h", bus.pc_cur, exp_pc);
      else n_pass++;
    end
    bus.branch_taken = 1'b0;
    settle();
    n_checks++;
    if (bus.flush !== 1'b0)
      $display("FAIL b2b_seq_flush: got %b expected 0", bus.flush);
    else n_pass++;
    exp_q.push_back(16'h2002);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL b2b_seq_pc: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
  endtask

  task automatic test_branch_halt_wrap;
    do_reset();
    bus.halt          = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'hFFFE;
    settle();
    n_checks++;
    if (bus.pc_we !== 1'b1 || bus.pc_next !== 16'hFFFE)
      $display("FAIL bh_branch_wins: we=%b pc_next=%h expected 1 FFFE",
               bus.pc_we, bus.pc_next);
    else n_pass++;
    exp_q.push_back(16'hFFFE);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc || bus.halted !== 1'b0)
      $display("FAIL bh_no_halt: pc_cur=%h halted=%b expected %h 0",
               bus.pc_cur, bus.halted, exp_pc);
    else n_pass++;
    bus.halt         = 1'b0;
    bus.branch_taken = 1'b0;
    settle();
    n_checks++;
    if (bus.pc_next !== 16'h0000)
      $display("FAIL bh_wrap_next: got %h expected 0000", bus.pc_next);
    else n_pass++;
    exp_q.push_back(16'h0000);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL bh_wrap_pc: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
    bus.halt = 1'b1;
    settle();
    n_checks++;
    if (bus.pc_we !== 1'b0)
      $display("FAIL bh_halt_accept_we: got %b expected 0", bus.pc_we);
    else n_pass++;
    exp_q.push_back(16'h0000);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc || bus.halted !== 1'b1)
      $display("FAIL bh_halted: pc_cur=%h halted=%b expected %h 1",
               bus.pc_cur, bus.halted, exp_pc);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      bus.halt          = 1'($urandom_range(0, 1));
      bus.stall         = 1'($urandom_range(0, 1));
      bus.imem_ready    = 1'(i % 2);
      bus.branch_taken  = 1'($urandom_range(0, 1));
      bus.branch_target = 16'($urandom_range(0, 16'hFFFF));
      settle();
      n_checks++;
      if ({bus.imem_req, bus.pc_we, bus.flush, bus.halted} !== 4'b0001)
        $display("FAIL bh_frozen_ctrl: req/we/flush/halted=%b expected 0001",
                 {bus.imem_req, bus.pc_we, bus.flush, bus.halted});
      else n_pass++;
      exp_q.push_back(16'h0000);
      tick();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (bus.pc_cur !== exp_pc)
        $display("FAIL bh_frozen_pc: got %h expected %h", bus.pc_cur, exp_pc);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.imem_ready    = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 16'h0ABC;
    tick();
    bus.branch_taken = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.pc_we !== 1'b1 || bus.pc_next !== 16'h0000 || bus.halted !== 1'b0)
      $display("FAIL rm_wait_reset: we=%b pc_next=%h halted=%b expected 1 0000 0",
               bus.pc_we, bus.pc_next, bus.halted);
    else n_pass++;
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    exp_q.push_back(16'h0000);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL rm_wait_pc0: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
    settle();
    n_checks++;
    if (bus.pc_next !== 16'h0002 || bus.flush !== 1'b0)
      $display("FAIL rm_no_stale: pc_next=%h flush=%b expected 0002 0",
               bus.pc_next, bus.flush);
    else n_pass++;
    exp_q.push_back(16'h0002);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL rm_wait_pc2: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.pc_we !== 1'b1 || bus.pc_next !== 16'h0000 || bus.halted !== 1'b0)
      $display("FAIL rm_halt_reset: we=%b pc_next=%h halted=%b expected 1 0000 0",
               bus.pc_we, bus.pc_next, bus.halted);
    else n_pass++;
    rst = 1'b0;
    exp_q.push_back(16'h0000);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc || bus.imem_req !== 1'b1)
      $display("FAIL rm_halt_resume: pc_cur=%h req=%b expected %h 1",
               bus.pc_cur, bus.imem_req, exp_pc);
    else n_pass++;
    exp_q.push_back(16'h0002);
    tick();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (bus.pc_cur !== exp_pc)
      $display("FAIL rm_halt_pc2: got %h expected %h", bus.pc_cur, exp_pc);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stall();
    test_redirect_miss();
    test_back_to_back();
    test_branch_halt_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-stage controller that sequences the 16-bit program counter register.
- Each cycle it decides whether the PC register loads, and with what value: reset vector, sequential PC+2, or branch target.
- Handles the instruction-memory ready handshake, pipeline stalls, branch redirects that arrive while a fetch is outstanding, and processor halt.
- Sits between decode/execute hazard logic, instruction memory, and the PC register.

Parameters:
- WIDTH, 16, PC and address width.
- INC, 2, sequential increment in bytes; one instruction is 16 bits.
- RESET_VEC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_cur  input  WIDTH  current PC register output.
- imem_ready  input  1  instruction memory returns the instruction for pc_cur this cycle.
- stall  input  1  hazard stall from decode; hold the PC.
- branch_taken  input  1  resolved taken branch or jump from execute.
- branch_target  input  WIDTH  redirect address; valid when branch_taken=1.
- halt  input  1  HLT instruction decoded.
- imem_req  output  1  fetch request to instruction memory at pc_cur.
- pc_next  output  WIDTH  value for the PC register to load.
- pc_we  output  1  PC register write enable.
- flush  output  1  squash the instruction in IF/ID.
- halted  output  1  processor halted (registered).

Behaviour:
- One clock, clk. Synchronous active-high reset, rst.
- State register: RESET, RUN, WAIT_REDIR, HALT. redir_target is a WIDTH register.
- rst=1 at an edge forces state to RESET, halted to 0 and redir_target to 0, regardless of the current state (including mid-WAIT_REDIR and HALT).
- imem_req, pc_next, pc_we and flush are combinational from state and inputs. halted is a registered output.
- pc_next defaults to pc_cur + INC, modulo 2^WIDTH; 16'hFFFE wraps to 16'h0000.
- RESET state:
  - imem_req=0, pc_we=1, pc_next=RESET_VEC, flush=1.
  - Next state is RUN. The first fetch occurs one cycle after rst deasserts.
- RUN state: imem_req=1. Priority, highest first:
  - 1. branch_taken=1 and imem_ready=1: pc_next=branch_target, pc_we=1, flush=1, stay in RUN.
  - 2. branch_taken=1 and imem_ready=0: pc_we=0, flush=1, redir_target<=branch_target, go to WAIT_REDIR.
  - 3. halt=1: pc_we=0, go to HALT. A branch in the same cycle wins, so the halt is squashed.
  - 4. stall=1: pc_we=0. The stall holds the PC even if imem_ready=1; the same address is refetched.
  - 5. imem_ready=1: pc_we=1, pc_next=pc_cur+INC.
  - 6. Otherwise pc_we=0, i.e. waiting on memory.
- WAIT_REDIR state (in-flight fetch belongs to the wrong path):
  - imem_req=1, flush=1 every cycle; stall and halt are ignored.
  - A new branch_taken=1 overwrites redir_target; the latest redirect wins.
  - When imem_ready=1: pc_next=redir_target, or branch_target if branch_taken is asserted that same cycle; pc_we=1, go to RUN.
- HALT state:
  - imem_req=0, pc_we=0, flush=0, halted=1 from the edge after entry.
  - All inputs are ignored; exit only via rst.
- Latency:
  - Branch with imem_ready=1: new PC is visible at pc_cur 1 cycle later.
  - Branch with imem_ready=0: new PC is visible 1 cycle after imem_ready rises.
- Invariant: pc_we=1 is never asserted in HALT or in the cycle halt is accepted.

Test Plan:
- Reset then run: rst=1 for 2 cycles, imem_ready=1 constant, PC register modelled -> pc_cur sequence 0000, 0002, 0004, 0006; imem_req=0 only in the RESET cycle.
- Stall: at pc_cur=0004 assert stall for 3 cycles with imem_ready=1 -> pc_we=0 for 3 cycles, pc_cur stays 0004, then 0006.
- Redirect during miss: imem_ready=0, pc_cur=0010, branch_taken=1 with target=0100 for 1 cycle; imem_ready rises 3 cycles later -> flush=1 for all 4 cycles; pc_cur=0100 the cycle after ready; 0012 never appears.
- Branch vs halt plus wrap: halt=1 and branch_taken=1 with target=FFFE in the same cycle -> no HALT, pc_cur=FFFE then 0000; a later lone halt=1 -> halted=1 next cycle, pc_cur frozen for more than 10 cycles despite branch and imem_ready toggling.
- Reset mid-operation: rst=1 while in WAIT_REDIR (and separately while in HALT) -> halted=0, pc_next=0000 with pc_we=1, normal fetch resumes at 0000; the stale redir_target is never loaded.
